decode_stage: RTL
=================

Name: decode_stage

Overview:
Registered, parametrised RISC-V instruction decode stage sitting between the fetch unit and the execute/issue stage.
- Accepts {instruction, pc} through a valid/ready handshake.
- Decodes fields and a type-classified, sign/zero-extended immediate at XLEN width.
- Holds results in a 2-entry skid buffer, so upstream ready never depends combinationally on downstream ready.
- Supports pipeline flush from branch/trap resolution.

Parameters:
XLEN, 32, datapath width of pc and immediate; legal values 32 or 64.
DEPTH, 2, skid-buffer entries; fixed at 2 (parameter reserved for future growth, values other than 2 are unsupported).

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  synchronous active-high reset
flush  input  1  discard all buffered entries this cycle
in_valid  input  1  upstream instruction valid
in_ready  output  1  stage can accept; registered, equals (count < 2)
in_ins  input  32  raw instruction word
in_pc  input  XLEN  pc of in_ins
out_valid  output  1  head entry valid
out_ready  input  1  downstream accepts head
out_pc  output  XLEN  pc of head
out_opcode  output  7  ins[6:0]
out_funct3  output  3  ins[14:12]
out_funct7  output  7  ins[31:25]
out_rs1  output  5  ins[19:15]
out_rs2  output  5  ins[24:20]
out_rd  output  5  ins[11:7]
out_csr_addr  output  12  ins[31:20]
out_imm  output  XLEN  decoded immediate
out_itype  output  6  one-hot {SYS,S,B,J,U,I}; all-zero for R-type/FENCE
out_illegal  output  1  unrecognised opcode (see Optional Feature)

Behaviour:
- Clock and reset: single clock clk; rst is synchronous, active-high.
- Decode is combinational on in_ins. The decoded bundle is written into the buffer on accept (in_valid & in_ready).
- Opcode classes:
  - I: JALR 1100111, LOAD 0000011, OP_IMM 0010011, OP_IMM32 0011011
  - U: LUI 0110111, AUIPC 0010111
  - J: JAL 1101111
  - B: 1100011
  - S: 0100011
  - SYS: 1110011
  - Recognised, no immediate: OP 0110011, OP_32 0111011, FENCE 0001111
- Immediates, extended to XLEN:
  - I: sext(ins[31:20])
  - S: sext({ins[31:25],ins[11:7]})
  - B: sext({ins[31],ins[7],ins[30:25],ins[11:8],0})
  - J: sext({ins[31],ins[19:12],ins[20],ins[30:21],0})
  - U: sext({ins[31:12],12'b0}); for XLEN=64, bits 63:32 copy ins[31]
  - SYS: zext(ins[31:20])
  - Others: 0
- Buffer: 2-entry FIFO with write pointer, read pointer and count (0..2). Outputs are driven from the head entry register (no combinational path from in_* to out_*).
- Latency: accept in cycle N with an empty buffer -> out_valid=1 with that entry in cycle N+1.
- Throughput: 1 instruction/cycle sustained when out_ready=1.
- Simultaneous push and pop at count=1 or count=2: count unchanged, order preserved. At count=2, in_ready=0, so a push cannot occur.
- Full: count=2 -> in_ready=0 the following cycle. in_ready is computed from registered count only.
- Empty: out_valid=0. out_* fields hold their last value (don't-care for consumers, but must not be X after reset).
- Pointer wrap: 1-bit pointers wrap 1->0.
- flush=1: next cycle count=0, out_valid=0, in_ready=1. An accept in the same cycle as flush is discarded. flush takes priority over push and pop.
- Reset: count=0, pointers=0, out_valid=0, in_ready=1, all out_* data=0, out_illegal=0. Reset mid-stream drops all entries identically to flush.

Optional Feature:
Macro DECODE_ILLEGAL_CHECK_EN.
- Defined: out_illegal=1 for any opcode outside the recognised list above, or when ins[1:0]!=2'b11. Such entries still flow through the buffer with out_itype=0 and out_imm=0.
- Undefined: out_illegal is tied to 0 and no check logic is built.

Test Plan:
- XLEN=32: push 0xFFF10093 (addi x1,x2,-1), pc 0x100 -> next cycle out_valid=1, out_itype=000001, out_imm=0xFFFFFFFF, rd=1, rs1=2, out_pc=0x100.
- XLEN=64: push 0x800002B7 (lui x5,0x80000) -> out_itype=000010, out_imm=0xFFFFFFFF80000000, rd=5.
- Push 0xFFDFF0EF (jal ra,-4) and 0x30009073 (csrrw x0,0x300,x1) back-to-back with out_ready=0 -> count=2, in_ready=0 next cycle. Then out_ready=1 -> pops in order: J imm=-4 sign-extended; then SYS imm=0x300, csr_addr=0x300, itype=100000.
- Streaming: 8 instructions with in_valid=out_ready=1 every cycle -> 8 outputs on 8 consecutive cycles, in order, in_ready stays 1.
- Buffer holding 2 entries; assert flush together with in_valid=1 -> next cycle out_valid=0, in_ready=1, flushed input never appears. Repeat the same sequence with rst instead of flush -> identical result.
- With DECODE_ILLEGAL_CHECK_EN: push 0x0000007F -> out_illegal=1, itype=0, imm=0. Push 0x00000013 -> out_illegal=0. Without the macro: both -> out_illegal=0.

Source files
------------

// File: rtl/decode_stage_if.sv
// Decode-stage bus interface.
// Carries the upstream {instruction, pc} valid/ready handshake and the
// downstream decoded-bundle valid/ready handshake.
//   master : the environment (fetch unit + execute/issue consumer)
//   slave  : the decode stage itself
// Upstream signals:   in_valid, in_ready, in_ins, in_pc
// Downstream signals: out_valid, out_ready, out_pc, out_opcode, out_funct3,
//                     out_funct7, out_rs1, out_rs2, out_rd, out_csr_addr,
//                     out_imm, out_itype, out_illegal
interface decode_stage_if #(
  parameter int unsigned XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_ins;
  logic [XLEN-1:0] in_pc;

  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [6:0]      out_opcode;
  logic [2:0]      out_funct3;
  logic [6:0]      out_funct7;
  logic [4:0]      out_rs1;
  logic [4:0]      out_rs2;
  logic [4:0]      out_rd;
  logic [11:0]     out_csr_addr;
  logic [XLEN-1:0] out_imm;
  logic [5:0]      out_itype;
  logic            out_illegal;

  modport master (
    output in_valid, in_ins, in_pc, out_ready,
    input  in_ready, out_valid, out_pc, out_opcode, out_funct3, out_funct7,
           out_rs1, out_rs2, out_rd, out_csr_addr, out_imm, out_itype,
           out_illegal
  );

  modport slave (
    input  in_valid, in_ins, in_pc, out_ready,
    output in_ready, out_valid, out_pc, out_opcode, out_funct3, out_funct7,
           out_rs1, out_rs2, out_rd, out_csr_addr, out_imm, out_itype,
           out_illegal
  );
endinterface

// File: rtl/decode_stage.sv
// Registered RISC-V instruction decode stage.
// Decodes the incoming instruction combinationally and stores the decoded
// bundle in a 2-entry skid buffer; all outputs come from the head entry
// register, and in_ready depends only on the registered occupancy count.
// Ports:
//   clk    - clock, all state on rising edge
//   rst    - synchronous active-high reset
//   flush  - discard all buffered entries (priority over push/pop)
//   bus    - decode_stage_if.slave: upstream in_* handshake, downstream
//            out_* handshake and decoded fields
// Parameters:
//   XLEN   - 32 or 64, width of pc and immediate
//   DEPTH  - skid-buffer entries, only 2 is supported
// Build option:
//   DECODE_ILLEGAL_CHECK_EN - when defined, out_illegal flags opcodes outside
//   the recognised set; otherwise out_illegal is constant 0.
module decode_stage #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 2
) (
  input logic           clk,
  input logic           rst,
  input logic           flush,
  decode_stage_if.slave bus
);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_IMM32  = 7'b0011011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_OP32   = 7'b0111011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  // one-hot itype bit positions: {SYS,S,B,J,U,I}
  localparam int unsigned IT_I   = 0;
  localparam int unsigned IT_U   = 1;
  localparam int unsigned IT_J   = 2;
  localparam int unsigned IT_B   = 3;
  localparam int unsigned IT_S   = 4;
  localparam int unsigned IT_SYS = 5;

  localparam logic [1:0] CNT_FULL = 2'(DEPTH);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     ins;
    logic [XLEN-1:0] imm;
    logic [5:0]      itype;
    logic            illegal;
  } entry_t;

  // ---------------------------------------------------------------------------
  // Combinational decode of the incoming word
  // ---------------------------------------------------------------------------
  logic [31:0]     ins;
  logic [6:0]      opcode;
  logic [XLEN-1:0] imm_d;
  logic [5:0]      itype_d;
  logic            illegal_d;
  logic [11:0]     i_imm12;
  logic [11:0]     s_imm12;
  logic [12:0]     b_imm13;
  logic [20:0]     j_imm21;
  logic [31:0]     u_imm32;

  assign ins    = bus.in_ins;
  assign opcode = ins[6:0];

  assign i_imm12 = ins[31:20];
  assign s_imm12 = {ins[31:25], ins[11:7]};
  assign b_imm13 = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
  assign j_imm21 = {ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
  assign u_imm32 = {ins[31:12], 12'b0};

  always_comb begin
    imm_d   = '0;
    itype_d = '0;
    case (opcode)
      OP_JALR, OP_LOAD, OP_IMM, OP_IMM32: begin
        itype_d[IT_I] = 1'b1;
        imm_d         = XLEN'($signed(i_imm12));
      end
      OP_LUI, OP_AUIPC: begin
        // sign extension from bit 31 gives the RV64 upper-word copy of ins[31]
        itype_d[IT_U] = 1'b1;
        imm_d         = XLEN'($signed(u_imm32));
      end
      OP_JAL: begin
        itype_d[IT_J] = 1'b1;
        imm_d         = XLEN'($signed(j_imm21));
      end
      OP_BRANCH: begin
        itype_d[IT_B] = 1'b1;
        imm_d         = XLEN'($signed(b_imm13));
      end
      OP_STORE: begin
        itype_d[IT_S] = 1'b1;
        imm_d         = XLEN'($signed(s_imm12));
      end
      OP_SYSTEM: begin
        itype_d[IT_SYS] = 1'b1;
        imm_d           = XLEN'(i_imm12);
      end
      default: begin
        imm_d   = '0;
        itype_d = '0;
      end
    endcase
  end

`ifdef DECODE_ILLEGAL_CHECK_EN
  // Every recognised opcode has ins[1:0]=2'b11, so a non-match also covers
  // compressed/invalid low bits.
  always_comb begin
    illegal_d = 1'b1;
    case (opcode)
      OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD, OP_STORE,
      OP_IMM, OP_IMM32, OP_OP, OP_OP32, OP_FENCE, OP_SYSTEM:
        illegal_d = 1'b0;
      default:
        illegal_d = 1'b1;
    endcase
  end
`else
  assign illegal_d = 1'b0;
`endif

  entry_t entry_d;

  always_comb begin
    entry_d         = '0;
    entry_d.pc      = bus.in_pc;
    entry_d.ins     = ins;
    entry_d.imm     = imm_d;
    entry_d.itype   = itype_d;
    entry_d.illegal = illegal_d;
  end

  // ---------------------------------------------------------------------------
  // 2-entry skid buffer
  // ---------------------------------------------------------------------------
  entry_t     mem_q [DEPTH];
  logic       wr_ptr_q;
  logic       rd_ptr_q;
  logic [1:0] count_q;
  logic       in_ready_w;
  logic       out_valid_w;
  logic       push;
  logic       pop;

  assign in_ready_w  = (count_q != CNT_FULL);
  assign out_valid_w = (count_q != 2'd0);
  assign push        = bus.in_valid & in_ready_w;
  assign pop         = out_valid_w & bus.out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q  <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (flush) begin
      // Realign the write pointer to the head so the held out_* value stays
      // the last one presented rather than jumping to another slot.
      count_q  <= '0;
      wr_ptr_q <= rd_ptr_q;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= entry_d;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs from the head register
  // ---------------------------------------------------------------------------
  entry_t head;
  assign head = mem_q[rd_ptr_q];

  assign bus.in_ready     = in_ready_w;
  assign bus.out_valid    = out_valid_w;
  assign bus.out_pc       = head.pc;
  assign bus.out_opcode   = head.ins[6:0];
  assign bus.out_funct3   = head.ins[14:12];
  assign bus.out_funct7   = head.ins[31:25];
  assign bus.out_rs1      = head.ins[19:15];
  assign bus.out_rs2      = head.ins[24:20];
  assign bus.out_rd       = head.ins[11:7];
  assign bus.out_csr_addr = head.ins[31:20];
  assign bus.out_imm      = head.imm;
  assign bus.out_itype    = head.itype;
  assign bus.out_illegal  = head.illegal;

endmodule
